// File: rtl/rr_arb.sv
// Round-robin / fixed-priority arbiter with per-port grant lock and registered one-hot grant.
// Pointer advances past each round-robin winner; a locked holder keeps its grant.
module rr_arb #(
    parameter int unsigned NUM_PORTS = 4,
    localparam int unsigned IDX_W = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] lock_i,
    input  logic                 mode_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic                 gnt_vld_o
);

    logic [NUM_PORTS-1:0]   r_gnt;
    logic [IDX_W-1:0]       r_gnt_idx;
    logic                   r_gnt_vld;
    logic [IDX_W-1:0]       r_ptr;

    logic [NUM_PORTS-1:0]   w_gnt_d;
    logic [IDX_W-1:0]       w_gnt_idx_d;
    logic                   w_gnt_vld_d;
    logic [IDX_W-1:0]       w_ptr_d;

    logic                   w_hold;
    logic [2*NUM_PORTS-1:0] w_req_rot;
    logic                   w_rr_found;
    logic [IDX_W-1:0]       w_rr_off;
    logic [IDX_W:0]         w_rr_sum;
    logic [IDX_W-1:0]       w_rr_idx;
    logic                   w_fp_found;
    logic [IDX_W-1:0]       w_fp_idx;
    logic                   w_found;
    logic [IDX_W-1:0]       w_win_idx;

    // Grant is one-hot, so any overlap with req & lock means the holder stays locked.
    assign w_hold = r_gnt_vld && (|(r_gnt & req_i & lock_i));

    // Rotate requests so bit 0 corresponds to the pointer position.
    assign w_req_rot = {req_i, req_i} >> r_ptr;

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_off   = '0;
        w_fp_found = 1'b0;
        w_fp_idx   = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (!w_rr_found && w_req_rot[i]) begin
                w_rr_found = 1'b1;
                w_rr_off   = IDX_W'(i);
            end
            if (!w_fp_found && req_i[i]) begin
                w_fp_found = 1'b1;
                w_fp_idx   = IDX_W'(i);
            end
        end
    end

    assign w_rr_sum = {1'b0, r_ptr} + {1'b0, w_rr_off};
    assign w_rr_idx = (w_rr_sum >= (IDX_W+1)'(NUM_PORTS))
                    ? IDX_W'(w_rr_sum - (IDX_W+1)'(NUM_PORTS))
                    : w_rr_sum[IDX_W-1:0];

    assign w_found   = mode_i ? w_fp_found : w_rr_found;
    assign w_win_idx = mode_i ? w_fp_idx : w_rr_idx;

    always_comb begin
        w_gnt_d     = '0;
        w_gnt_idx_d = '0;
        w_gnt_vld_d = 1'b0;
        w_ptr_d     = r_ptr;
        if (w_hold) begin
            w_gnt_d     = r_gnt;
            w_gnt_idx_d = r_gnt_idx;
            w_gnt_vld_d = 1'b1;
        end else if (w_found) begin
            w_gnt_d     = NUM_PORTS'(1) << w_win_idx;
            w_gnt_idx_d = w_win_idx;
            w_gnt_vld_d = 1'b1;
            if (!mode_i) begin
                w_ptr_d = (w_win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_win_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_gnt     <= w_gnt_d;
            r_gnt_idx <= w_gnt_idx_d;
            r_gnt_vld <= w_gnt_vld_d;
            r_ptr     <= w_ptr_d;
        end
    end

    assign gnt_o     = r_gnt;
    assign gnt_idx_o = r_gnt_idx;
    assign gnt_vld_o = r_gnt_vld;

endmodule

// File: tb/tb_rr_arb.sv
// Directed vector table plus reset and randomized-invariant sequences for rr_arb (4 ports).
module tb_rr_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_i;
    logic [3:0] lock_i;
    logic       mode_i;
    logic [3:0] gnt_o;
    logic [1:0] gnt_idx_o;
    logic       gnt_vld_o;

    int n_cmp  = 0;
    int n_fail = 0;

    rr_arb #(.NUM_PORTS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .lock_i    (lock_i),
        .mode_i    (mode_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o),
        .gnt_vld_o (gnt_vld_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       mode;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic [1:0] ptr;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] lock, input logic mode,
                                input logic [3:0] gnt, input logic [1:0] idx, input logic vld,
                                input logic [1:0] ptr);
        vec_t v;
        v.req = req; v.lock = lock; v.mode = mode;
        v.gnt = gnt; v.idx = idx; v.vld = vld; v.ptr = ptr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] g, input logic [1:0] idx,
                             input logic vld, input logic [1:0] ptr);
        check({name, " gnt"}, 32'(gnt_o), 32'(g));
        check({name, " idx"}, 32'(gnt_idx_o), 32'(idx));
        check({name, " vld"}, 32'(gnt_vld_o), 32'(vld));
        check({name, " ptr"}, 32'(dut.r_ptr), 32'(ptr));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic       m_vld;
    logic [1:0] m_idx;
    logic [1:0] m_ptr;
    logic       m_found;
    logic [1:0] m_w;
    logic [3:0] m_gnt;
    int         j;

    initial begin
        reset  = 1'b1;
        req_i  = 4'b0000;
        lock_i = 4'b0000;
        mode_i = 1'b0;
        #2;
        check_all("reset_async", 4'b0000, 2'd0, 1'b0, 2'd0);
        #10;
        reset = 1'b0;

        // Rotation
        vecs[0]  = mk(4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd1);
        vecs[1]  = mk(4'b1111, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd2);
        vecs[2]  = mk(4'b1111, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd3);
        vecs[3]  = mk(4'b1111, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd0);
        vecs[4]  = mk(4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd1);
        // Fixed priority, ptr frozen
        vecs[5]  = mk(4'b1110, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 2'd1);
        vecs[6]  = mk(4'b1110, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 2'd1);
        vecs[7]  = mk(4'b1110, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 2'd1);
        // Lock on a non-granted port is ignored, then port 2 is won and held
        vecs[8]  = mk(4'b1111, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd2);
        vecs[9]  = mk(4'b1111, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd3);
        vecs[10] = mk(4'b1111, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd3);
        vecs[11] = mk(4'b1111, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd3);
        vecs[12] = mk(4'b1111, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd3);
        vecs[13] = mk(4'b1111, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd0);
        // Bring ptr to 2, idle, then wrap
        vecs[14] = mk(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd1);
        vecs[15] = mk(4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd2);
        vecs[16] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd2);
        vecs[17] = mk(4'b1001, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd0);
        vecs[18] = mk(4'b1001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd1);
        // Released holder stays eligible in the same cycle
        vecs[19] = mk(4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd1);
        vecs[20] = mk(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd1);
        // Lock survives a switch to fixed mode
        vecs[21] = mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd3);
        vecs[22] = mk(4'b0101, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd3);
        vecs[23] = mk(4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd3);
        vecs[24] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd3);

        for (int i = 0; i < 25; i++) begin
            req_i  = vecs[i].req;
            lock_i = vecs[i].lock;
            mode_i = vecs[i].mode;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].vld,
                      vecs[i].ptr);
        end

        // Locked grant on port 2, then async reset between edges
        req_i  = 4'b0100;
        lock_i = 4'b0100;
        mode_i = 1'b0;
        step();
        check_all("lock_setup", 4'b0100, 2'd2, 1'b1, 2'd3);
        step();
        check_all("lock_held", 4'b0100, 2'd2, 1'b1, 2'd3);
        #2;
        reset = 1'b1;
        #1;
        check_all("reset_midcycle", 4'b0000, 2'd0, 1'b0, 2'd0);
        step();
        check_all("reset_held", 4'b0000, 2'd0, 1'b0, 2'd0);
        reset  = 1'b0;
        req_i  = 4'b1111;
        lock_i = 4'b0000;
        step();
        check_all("after_reset", 4'b0001, 2'd0, 1'b1, 2'd1);

        // Random phase: invariants plus an independent reference model
        m_vld = 1'b1;
        m_idx = 2'd0;
        m_ptr = 2'd1;
        for (int c = 0; c < 200; c++) begin
            req_i  = 4'($urandom);
            lock_i = 4'($urandom) & 4'($urandom);
            mode_i = ($urandom_range(0, 3) == 0);
            if (m_vld && req_i[m_idx] && lock_i[m_idx]) begin
                // holder keeps grant
            end else begin
                m_found = 1'b0;
                m_w     = 2'd0;
                for (int k = 0; k < 4; k++) begin
                    j = mode_i ? k : (int'(m_ptr) + k) % 4;
                    if (!m_found && req_i[j]) begin
                        m_found = 1'b1;
                        m_w     = 2'(j);
                    end
                end
                m_vld = m_found;
                m_idx = m_found ? m_w : 2'd0;
                if (m_found && !mode_i) m_ptr = 2'((int'(m_w) + 1) % 4);
            end
            m_gnt = m_vld ? (4'b0001 << m_idx) : 4'b0000;
            step();
            check("rnd onehot0", 32'($onehot0(gnt_o)), 32'd1);
            check("rnd idx_match", 32'(gnt_vld_o ? (4'b0001 << gnt_idx_o) : 4'b0000),
                  32'(gnt_o));
            check("rnd vld_or", 32'(gnt_vld_o), 32'(|gnt_o));
            check("rnd gnt_req", 32'(gnt_o & ~req_i), 32'd0);
            check("rnd model_gnt", 32'(gnt_o), 32'(m_gnt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
